water_cycle_controller: RTL and testbench
=========================================

WATER_CYCLE_CONTROLLER -- requirements
Module: water_cycle_controller

Interface
REQ-001 SHALL have parameter THRESHOLD, default 10, meaning the minimum level change per monitor window.
REQ-002 SHALL have parameter WINDOW, default 10, meaning the monitor window length in clk cycles.
REQ-003 SHALL have parameter HOLD_CYCLES, default 20, meaning the soak duration between fill and drain.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begins a fill/hold/drain cycle.
REQ-007 SHALL have port abort, input, 1 bit: skips directly to drain.
REQ-008 SHALL have port clear_fault, input, 1 bit: leaves FAULT.
REQ-009 SHALL have port fill_target, input, 10 bits: level at which fill ends.
REQ-010 SHALL have port drain_target, input, 10 bits: level at which drain ends.
REQ-011 SHALL have port water_level_sensor, input, 10 bits: current water level.
REQ-012 SHALL have port fill_valve, output, 1 bit: valve open command.
REQ-013 SHALL have port drain_pump, output, 1 bit: pump on command.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE or FAULT.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port error_flag, output, 1 bit: high while in FAULT.
REQ-017 SHALL have port state, output, 3 bits: IDLE=0, FILL=1, HOLD=2, DRAIN=3, FAULT=4.

Function
REQ-018 SHALL implement the FSM IDLE->FILL->HOLD->DRAIN->IDLE, with FAULT reachable from FILL and DRAIN.
REQ-019 SHALL, in IDLE with start=1 at an edge, enter FILL on the next cycle; start SHALL be ignored in all other states.
REQ-020 SHALL drive all outputs as registered functions of state: fill_valve=1 only in FILL, drain_pump=1 only in DRAIN.
REQ-021 SHALL, in FILL, go to HOLD at the first edge with water_level_sensor >= fill_target (unsigned compare); FILL always lasts at least 1 cycle.
REQ-022 SHALL, in HOLD, count HOLD_CYCLES cycles, then go to DRAIN.
REQ-023 SHALL, in DRAIN, go to IDLE at the first edge with water_level_sensor <= drain_target, and pulse done=1 for exactly the first IDLE cycle.
REQ-024 SHALL capture a baseline of water_level_sensor and zero a window counter on entry to FILL or DRAIN and at every window expiry (counter = WINDOW-1).
REQ-025 SHALL, at window expiry, compute progress as level-baseline (FILL) or baseline-level (DRAIN), clamped to 0 when negative (no 10-bit wrap), and go to FAULT if progress < THRESHOLD.
REQ-026 SHALL give target-reached priority over a simultaneous window-expiry fault.
REQ-027 SHALL, on abort=1 in FILL or HOLD, go to DRAIN next cycle and restart the monitor; abort SHALL be ignored in IDLE, DRAIN and FAULT.
REQ-028 SHALL close the valve and stop the pump in FAULT, and leave FAULT only via clear_fault=1 (to IDLE, no done pulse) or reset.
REQ-029 SHALL give priority clear_fault > abort > start where these apply in the same state.

Reset
REQ-030 SHALL, while reset=1 at any time including mid-cycle, immediately force state=IDLE, all outputs 0, and all counters and baseline to 0.
REQ-031 SHALL resume normal operation at the first clk edge after reset deasserts; no pending start is retained.

Verification
REQ-032 Normal cycle: fill_target=200, drain_target=20, level 50 rising +20 per 2 cycles; assert start -> FILL, HOLD after level >= 200, 20 HOLD cycles, DRAIN; level falls -20 per 2 cycles -> IDLE with one done pulse, error_flag=0.
REQ-033 Stalled fill: level held at 100 during FILL -> FAULT after exactly WINDOW=10 cycles, error_flag=1, fill_valve=0; clear_fault -> IDLE, done=0.
REQ-034 Slow drain: level falls by 5 per 2 cycles in DRAIN (25 per window, passes); then by 1 per 2 cycles (5 per window < 10) -> FAULT at that window's expiry.
REQ-035 Abort in HOLD -> drain_pump=1 on the next cycle; start pulsed during DRAIN -> no effect.
REQ-036 Boundary cases: level reaches 200 on the expiry cycle with insufficient progress -> HOLD, not FAULT; level decreases during FILL -> progress clamped to 0 -> FAULT with no wrap-induced pass.
REQ-037 Reset asserted mid-FILL between clk edges -> outputs 0 and state=0 immediately; after release, the controller stays IDLE until a new start.

Source files
------------

// File: rtl/water_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : water_cycle_controller
// Description : Fill / hold / drain sequencer with level-progress monitoring.
//               A stalled fill or drain (too little level change within one
//               monitor window) drops the controller into FAULT.
// Revision    : 1.0 - initial release
// ============================================================================
module water_cycle_controller #(
    parameter int THRESHOLD   = 10,
    parameter int WINDOW      = 10,
    parameter int HOLD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       clear_fault,
    input  logic [9:0] fill_target,
    input  logic [9:0] drain_target,
    input  logic [9:0] water_level_sensor,
    output logic       fill_valve,
    output logic       drain_pump,
    output logic       busy,
    output logic       done,
    output logic       error_flag,
    output logic [2:0] state
);

    localparam int         WW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int         HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [9:0]    THRESH    = 10'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [9:0]    r_baseline;
    logic [9:0]    w_baseline;
    logic [WW-1:0] r_wcnt;
    logic [WW-1:0] w_wcnt;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt;
    logic          r_done;
    logic          w_done;

    logic          w_expiry;
    logic [9:0]    w_fill_prog;
    logic [9:0]    w_drain_prog;

    // Progress since the window baseline, clamped at zero so a level moving
    // the wrong way can never wrap into a large "good" value.
    assign w_expiry     = (r_wcnt == WIN_LAST);
    assign w_fill_prog  = (water_level_sensor > r_baseline) ?
                          (water_level_sensor - r_baseline) : 10'd0;
    assign w_drain_prog = (r_baseline > water_level_sensor) ?
                          (r_baseline - water_level_sensor) : 10'd0;

    // Outputs decode straight from the state register so reset clears them at once.
    assign fill_valve = (r_state == S_FILL);
    assign drain_pump = (r_state == S_DRAIN);
    assign busy       = (r_state == S_FILL) || (r_state == S_HOLD) || (r_state == S_DRAIN);
    assign error_flag = (r_state == S_FAULT);
    assign done       = r_done;
    assign state      = r_state;

    // State register plus monitor/hold counters and baseline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baseline <= 10'd0;
            r_wcnt     <= '0;
            r_hcnt     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_baseline <= w_baseline;
            r_wcnt     <= w_wcnt;
            r_hcnt     <= w_hcnt;
            r_done     <= w_done;
        end
    end

    // Next-state logic; target reached outranks a window fault, abort outranks both.
    always_comb begin
        w_next     = r_state;
        w_baseline = r_baseline;
        w_wcnt     = r_wcnt + 1'b1;
        w_hcnt     = r_hcnt;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_wcnt = '0;
                if (start) begin
                    w_next     = S_FILL;
                    w_baseline = water_level_sensor;
                end
            end

            S_FILL: begin
                if (abort) begin
                    w_next     = S_DRAIN;
                    w_baseline = water_level_sensor;
                    w_wcnt     = '0;
                end else if (water_level_sensor >= fill_target) begin
                    w_next = S_HOLD;
                    w_wcnt = '0;
                    w_hcnt = '0;
                end else if (w_expiry) begin
                    w_wcnt = '0;
                    if (w_fill_prog < THRESH) begin
                        w_next = S_FAULT;
                    end else begin
                        w_baseline = water_level_sensor;
                    end
                end
            end

            S_HOLD: begin
                w_wcnt = '0;
                if (abort || (r_hcnt == HOLD_LAST)) begin
                    w_next     = S_DRAIN;
                    w_baseline = water_level_sensor;
                    w_hcnt     = '0;
                end else begin
                    w_hcnt = r_hcnt + 1'b1;
                end
            end

            S_DRAIN: begin
                if (water_level_sensor <= drain_target) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                    w_wcnt = '0;
                end else if (w_expiry) begin
                    w_wcnt = '0;
                    if (w_drain_prog < THRESH) begin
                        w_next = S_FAULT;
                    end else begin
                        w_baseline = water_level_sensor;
                    end
                end
            end

            S_FAULT: begin
                w_wcnt = '0;
                if (clear_fault) begin
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
                w_wcnt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_water_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_water_cycle_controller
// Description : Directed self-checking bench for water_cycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_water_cycle_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       clear_fault;
    logic [9:0] fill_target;
    logic [9:0] drain_target;
    logic [9:0] level;
    logic       fill_valve;
    logic       drain_pump;
    logic       busy;
    logic       done;
    logic       error_flag;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int n;

    water_cycle_controller #(
        .THRESHOLD  (10),
        .WINDOW     (10),
        .HOLD_CYCLES(20)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .clear_fault       (clear_fault),
        .fill_target       (fill_target),
        .drain_target      (drain_target),
        .water_level_sensor(level),
        .fill_valve        (fill_valve),
        .drain_pump        (drain_pump),
        .busy              (busy),
        .done              (done),
        .error_flag        (error_flag),
        .state             (state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Steps while the DUT stays in st, ramping level by delta every 'every' steps.
    task automatic run_ramp(input logic [2:0] st, input int delta, input int every,
                            input int limit, output int cnt);
        cnt = 0;
        while (state == st && cnt < limit) begin
            if (every > 0) begin
                if (cnt % every == every - 1) level = 10'(int'(level) + delta);
            end
            step();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; clear_fault = 1'b0;
        fill_target = 10'd200; drain_target = 10'd20; level = 10'd50;
        #2;
        check_val("rst_state", state, 0);
        check_val("rst_outs", {fill_valve, drain_pump, busy, done, error_flag}, 0);
        step();
        reset = 1'b0;
        step();
        check_val("idle_after_rst", state, 0);

        // Normal cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("norm_fill", state, 1);
        check_val("norm_valve", fill_valve, 1);
        check_val("norm_busy", busy, 1);
        run_ramp(3'd1, 20, 2, 100, n);
        check_val("norm_fill_len", n, 16);
        check_val("norm_hold", state, 2);
        check_val("norm_hold_valve", fill_valve, 0);
        run_ramp(3'd2, 0, 0, 100, n);
        check_val("norm_hold_len", n, 20);
        check_val("norm_drain", state, 3);
        check_val("norm_pump", drain_pump, 1);
        run_ramp(3'd3, -20, 2, 100, n);
        check_val("norm_drain_len", n, 20);
        check_val("norm_idle", state, 0);
        check_val("norm_done", done, 1);
        check_val("norm_err", error_flag, 0);
        step();
        check_val("norm_done_once", done, 0);

        // Stalled fill
        level = 10'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        run_ramp(3'd1, 0, 0, 100, n);
        check_val("stall_len", n, 10);
        check_val("stall_state", state, 4);
        check_val("stall_err", error_flag, 1);
        check_val("stall_valve", fill_valve, 0);
        check_val("stall_busy", busy, 0);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check_val("stall_clr", state, 0);
        check_val("stall_clr_done", done, 0);

        // Abort in HOLD, then slow drain; start/abort during DRAIN ignored
        level = 10'd100; fill_target = 10'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_val("ab_hold", state, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("ab_drain", state, 3);
        check_val("ab_pump", drain_pump, 1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) level = (i < 10) ? level - 10'd5 : level - 10'd1;
            start = (i == 4);
            abort = (i == 6);
            step();
            if (i == 4) check_val("drain_start_ign", state, 3);
            if (i == 6) check_val("drain_abort_ign", state, 3);
            if (i == 9) check_val("slow_pass", state, 3);
        end
        start = 1'b0; abort = 1'b0;
        check_val("slow_fault", state, 4);
        check_val("slow_pump", drain_pump, 0);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check_val("slow_clr", state, 0);

        // Target reached on the expiry edge beats the window fault
        level = 10'd195; fill_target = 10'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            level = (i == 9) ? 10'd200 : 10'd195;
            step();
            if (i == 8) check_val("edge_still_fill", state, 1);
        end
        check_val("edge_hold", state, 2);
        check_val("edge_err", error_flag, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        level = 10'd10;
        step();
        check_val("edge_idle", state, 0);
        check_val("edge_done", done, 1);

        // Falling level during FILL clamps to zero progress
        level = 10'd500; fill_target = 10'd900;
        start = 1'b1;
        step();
        start = 1'b0;
        run_ramp(3'd1, -10, 1, 100, n);
        check_val("clamp_len", n, 10);
        check_val("clamp_fault", state, 4);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;

        // Asynchronous reset mid-FILL
        level = 10'd100; fill_target = 10'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_val("mid_fill", state, 1);
        #3;
        reset = 1'b1;
        start = 1'b1;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_outs", {fill_valve, drain_pump, busy, done, error_flag}, 0);
        step();
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_val("post_rst_idle", state, 0);
        check_val("post_rst_valve", fill_valve, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
